// File: rtl/data_memory_pkg.sv
// Shared encodings for the sized data memory: access sizes and controller states.
package data_memory_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/mem_load_align.sv
// Load lane selection: picks the addressed byte/half/word out of a slot and
// extends it to the full slot width, signed or unsigned.
module mem_load_align
    import data_memory_pkg::*;
#(
    parameter  int SLOT_SIZE = 32,
    localparam int BYTES     = SLOT_SIZE / 8,
    localparam int OFS       = $clog2(BYTES)
) (
    input  logic [SLOT_SIZE-1:0] word_i,
    input  logic [OFS-1:0]       ofs_i,
    input  logic [1:0]           size_i,
    input  logic                 signed_i,
    output logic [SLOT_SIZE-1:0] data_o
);

    logic [SLOT_SIZE-1:0] shifted;

    // Little-endian: lane n sits at bits [8n+7:8n], so shifting right brings it to lane 0.
    assign shifted = word_i >> {ofs_i, 3'b000};

    // NOTE: combinational blocks assign a default first so no path leaves
    // data_o unassigned, which would otherwise infer a latch.
    always_comb begin
        data_o = word_i;
        case (size_i)
            SIZE_BYTE: data_o = signed_i ? SLOT_SIZE'($signed(shifted[7:0]))
                                         : SLOT_SIZE'(shifted[7:0]);
            SIZE_HALF: data_o = signed_i ? SLOT_SIZE'($signed(shifted[15:0]))
                                         : SLOT_SIZE'(shifted[15:0]);
            default:   data_o = word_i;
        endcase
    end

endmodule

// File: rtl/data_memory_sized.sv
// Byte-addressable MEM-stage data memory: sized loads/stores with alignment
// checking, one-cycle registered reads, and a sequential flush engine.
module data_memory_sized
    import data_memory_pkg::*;
#(
    parameter  int ADDR_SIZE = 5,
    parameter  int SLOT_SIZE = 32,
    localparam int BYTES     = SLOT_SIZE / 8,
    localparam int HALVES    = BYTES / 2,
    localparam int OFS       = $clog2(BYTES),
    localparam int BADDR     = ADDR_SIZE + OFS,
    localparam int DEPTH     = 2 ** ADDR_SIZE
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_flush,
    input  logic                       i_req,
    input  logic                       i_wr_rd,
    input  logic [1:0]                 i_size,
    input  logic                       i_signed,
    input  logic [BADDR-1:0]           i_addr,
    input  logic [SLOT_SIZE-1:0]       i_data,
    output logic [SLOT_SIZE-1:0]       o_data,
    output logic                       o_valid,
    output logic                       o_error,
    output logic                       o_ready,
    output logic [DEPTH*SLOT_SIZE-1:0] o_bus_debug
);

    state_e               state_q, state_d;
    logic [ADDR_SIZE-1:0] cnt_q, cnt_d;
    logic [SLOT_SIZE-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 error_q, error_d;
    logic [SLOT_SIZE-1:0] mem_q [DEPTH];

    logic [ADDR_SIZE-1:0] word_idx;
    logic [OFS-1:0]       lane_ofs;
    logic [OFS-1:0]       half_lane;
    logic                 misaligned;
    logic                 req_taken;
    logic                 store_en;
    logic                 load_en;
    logic                 flush_we;
    logic [BYTES-1:0]     byte_en;
    logic [SLOT_SIZE-1:0] wr_mask;
    logic [SLOT_SIZE-1:0] wr_data;
    logic [SLOT_SIZE-1:0] rd_word;
    logic [SLOT_SIZE-1:0] load_val;

    assign word_idx  = i_addr[BADDR-1:OFS];
    assign lane_ofs  = i_addr[OFS-1:0];
    assign half_lane = lane_ofs & ~OFS'(1);
    assign rd_word   = mem_q[word_idx];

    always_comb begin
        misaligned = 1'b0;
        case (i_size)
            SIZE_HALF: misaligned = lane_ofs[0];
            SIZE_WORD: misaligned = (lane_ofs != '0);
            SIZE_RSVD: misaligned = 1'b1;
            default:   misaligned = 1'b0;
        endcase
    end

    // A flush in IDLE takes priority and silently swallows any concurrent request.
    assign req_taken = i_req && (state_q == ST_IDLE) && !i_flush;
    assign store_en  = req_taken && !misaligned && i_wr_rd;
    assign load_en   = req_taken && !misaligned && !i_wr_rd;

    // ---------------- FSM: state register ----------------
    // NOTE: clocked state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q <= ST_FLUSH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_FLUSH: begin
                cnt_d = cnt_q + ADDR_SIZE'(1);
                if (cnt_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (i_flush) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_ready  = (state_q == ST_IDLE);
        flush_we = (state_q == ST_FLUSH);
        valid_d  = load_en;
        error_d  = req_taken && misaligned;
        data_d   = load_en ? load_val : data_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    // Store lane merge: replicate the right-aligned data across the slot and
    // let the byte enables pick which lanes actually change.
    always_comb begin
        byte_en = '0;
        wr_data = i_data;
        case (i_size)
            SIZE_BYTE: begin
                byte_en[lane_ofs] = 1'b1;
                wr_data           = {BYTES{i_data[7:0]}};
            end
            SIZE_HALF: begin
                byte_en[half_lane]            = 1'b1;
                byte_en[half_lane | OFS'(1)]  = 1'b1;
                wr_data                       = {HALVES{i_data[15:0]}};
            end
            SIZE_WORD: byte_en = '1;
            default:   byte_en = '0;
        endcase
        for (int b = 0; b < BYTES; b++) begin
            wr_mask[b*8 +: 8] = {8{byte_en[b]}};
        end
    end

    // NOTE: the array has no reset branch; it is cleared by the flush engine
    // instead, which keeps it mappable to plain RAM.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            if (flush_we) begin
                mem_q[cnt_q] <= '0;
            end else if (store_en) begin
                mem_q[word_idx] <= (rd_word & ~wr_mask) | (wr_data & wr_mask);
            end
        end
    end

    mem_load_align #(
        .SLOT_SIZE (SLOT_SIZE)
    ) u_load_align (
        .word_i   (rd_word),
        .ofs_i    (lane_ofs),
        .size_i   (i_size),
        .signed_i (i_signed),
        .data_o   (load_val)
    );

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            o_bus_debug[k*SLOT_SIZE +: SLOT_SIZE] = mem_q[k];
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_error = error_q;

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized (ADDR_SIZE=5, SLOT_SIZE=32) with
// hand-computed expected values.
module tb_data_memory_sized;
    import data_memory_pkg::*;

    localparam int ADDR_SIZE = 5;
    localparam int SLOT_SIZE = 32;
    localparam int BADDR     = 7;
    localparam int BUS_W     = 32 * 32;

    logic                 clk = 1'b0;
    logic                 i_reset;
    logic                 i_flush;
    logic                 i_req;
    logic                 i_wr_rd;
    logic [1:0]           i_size;
    logic                 i_signed;
    logic [BADDR-1:0]     i_addr;
    logic [SLOT_SIZE-1:0] i_data;
    logic [SLOT_SIZE-1:0] o_data;
    logic                 o_valid;
    logic                 o_error;
    logic                 o_ready;
    logic [BUS_W-1:0]     o_bus_debug;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_memory_sized #(
        .ADDR_SIZE (ADDR_SIZE),
        .SLOT_SIZE (SLOT_SIZE)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_flush     (i_flush),
        .i_req       (i_req),
        .i_wr_rd     (i_wr_rd),
        .i_size      (i_size),
        .i_signed    (i_signed),
        .i_addr      (i_addr),
        .i_data      (i_data),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_error     (o_error),
        .o_ready     (o_ready),
        .o_bus_debug (o_bus_debug)
    );

    task automatic check(input string tag, input logic [BUS_W-1:0] got, input logic [BUS_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1ns after the rising edge, inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic wr, input logic [1:0] size, input logic sgn,
                          input logic [BADDR-1:0] addr, input logic [31:0] data);
        i_req    = 1'b1;
        i_wr_rd  = wr;
        i_size   = size;
        i_signed = sgn;
        i_addr   = addr;
        i_data   = data;
        tick();
        i_req    = 1'b0;
    endtask

    function automatic logic [31:0] word_at(input int k);
        return o_bus_debug[k*32 +: 32];
    endfunction

    task automatic wait_ready(output int cycles, output bit saw_resp);
        cycles   = 0;
        saw_resp = 1'b0;
        while (!o_ready && cycles < 100) begin
            tick();
            cycles++;
            if (o_valid || o_error) saw_resp = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  cycles;
        bit  saw;

        i_reset = 1'b0; i_flush = 1'b0; i_req = 1'b0; i_wr_rd = 1'b0;
        i_size = SIZE_WORD; i_signed = 1'b0; i_addr = '0; i_data = '0;

        // 1. reset and release
        tick(); tick(); tick();
        check("rst_ready", BUS_W'(o_ready), BUS_W'(0));
        check("rst_data",  BUS_W'(o_data),  BUS_W'(0));
        check("rst_valid", BUS_W'(o_valid), BUS_W'(0));
        i_reset = 1'b1;
        wait_ready(cycles, saw);
        check("rst_flush_cycles", BUS_W'(cycles), BUS_W'(32));
        check("rst_bus_zero", o_bus_debug, '0);
        check("rst_data_after", BUS_W'(o_data), BUS_W'(0));

        // 2. word store then back-to-back word load
        access(1'b1, SIZE_WORD, 1'b0, 7'h08, 32'hDEADBEEF);
        check("st_word_novalid", BUS_W'(o_valid), BUS_W'(0));
        check("st_word_bus", BUS_W'(word_at(2)), BUS_W'(32'hDEADBEEF));
        access(1'b0, SIZE_WORD, 1'b0, 7'h08, 32'h0);
        check("ld_word_valid", BUS_W'(o_valid), BUS_W'(1));
        check("ld_word_data", BUS_W'(o_data), BUS_W'(32'hDEADBEEF));
        tick();
        check("ld_word_pulse", BUS_W'(o_valid), BUS_W'(0));
        check("ld_word_hold", BUS_W'(o_data), BUS_W'(32'hDEADBEEF));

        // 3. byte / half stores and loads on word 3
        access(1'b1, SIZE_WORD, 1'b0, 7'h0C, 32'h11223344);
        access(1'b1, SIZE_BYTE, 1'b0, 7'h0D, 32'hAAAAAA80);
        check("st_byte_merge", BUS_W'(word_at(3)), BUS_W'(32'h11228044));
        access(1'b0, SIZE_BYTE, 1'b1, 7'h0D, 32'h0);
        check("ld_byte_s", BUS_W'(o_data), BUS_W'(32'hFFFFFF80));
        access(1'b0, SIZE_BYTE, 1'b0, 7'h0D, 32'h0);
        check("ld_byte_u", BUS_W'(o_data), BUS_W'(32'h00000080));
        access(1'b0, SIZE_HALF, 1'b1, 7'h0E, 32'h0);
        check("ld_half_s_pos", BUS_W'(o_data), BUS_W'(32'h00001122));
        access(1'b1, SIZE_HALF, 1'b0, 7'h0E, 32'h5555BEEF);
        check("st_half_merge", BUS_W'(word_at(3)), BUS_W'(32'hBEEF8044));
        access(1'b0, SIZE_HALF, 1'b1, 7'h0E, 32'h0);
        check("ld_half_s_neg", BUS_W'(o_data), BUS_W'(32'hFFFFBEEF));
        access(1'b0, SIZE_BYTE, 1'b1, 7'h0C, 32'h0);
        check("ld_byte_lane0", BUS_W'(o_data), BUS_W'(32'h00000044));
        access(1'b0, SIZE_BYTE, 1'b0, 7'h0F, 32'h0);
        check("ld_byte_lane3", BUS_W'(o_data), BUS_W'(32'h000000BE));
        access(1'b0, SIZE_WORD, 1'b1, 7'h0C, 32'h0);
        check("ld_word_signed_ign", BUS_W'(o_data), BUS_W'(32'hBEEF8044));

        // 4. misaligned and reserved requests
        access(1'b0, SIZE_HALF, 1'b0, 7'h03, 32'h0);
        check("mis_half_err", BUS_W'(o_error), BUS_W'(1));
        check("mis_half_novalid", BUS_W'(o_valid), BUS_W'(0));
        check("mis_half_data", BUS_W'(o_data), BUS_W'(32'hBEEF8044));
        tick();
        check("mis_err_pulse", BUS_W'(o_error), BUS_W'(0));
        access(1'b1, SIZE_WORD, 1'b0, 7'h04, 32'h12345678);
        access(1'b1, SIZE_WORD, 1'b0, 7'h06, 32'hCAFEBABE);
        check("mis_word_err", BUS_W'(o_error), BUS_W'(1));
        check("mis_word_unchanged", BUS_W'(word_at(1)), BUS_W'(32'h12345678));
        access(1'b0, SIZE_RSVD, 1'b0, 7'h00, 32'h0);
        check("rsvd_err", BUS_W'(o_error), BUS_W'(1));
        check("rsvd_novalid", BUS_W'(o_valid), BUS_W'(0));

        // 5a. flush with a concurrent store, requests held during the flush
        i_flush = 1'b1;
        access(1'b1, SIZE_WORD, 1'b0, 7'h10, 32'h55555555);
        i_flush = 1'b0;
        check("flush_noerr", BUS_W'(o_error), BUS_W'(0));
        check("flush_ready_low", BUS_W'(o_ready), BUS_W'(0));
        i_req = 1'b1; i_wr_rd = 1'b0; i_size = SIZE_WORD; i_addr = 7'h0C;
        wait_ready(cycles, saw);
        i_req = 1'b0;
        check("flush_cycles", BUS_W'(cycles), BUS_W'(32));
        check("flush_no_resp", BUS_W'(saw), BUS_W'(0));
        check("flush_bus_zero", o_bus_debug, '0);
        check("flush_data_hold", BUS_W'(o_data), BUS_W'(32'hBEEF8044));

        // 5b. reset asserted at flush cycle 10 restarts the flush
        access(1'b1, SIZE_WORD, 1'b0, 7'h7C, 32'h0BADF00D);
        check("pre_rst_word31", BUS_W'(word_at(31)), BUS_W'(32'h0BADF00D));
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        i_reset = 1'b0;
        tick();
        check("midrst_data", BUS_W'(o_data), BUS_W'(0));
        check("midrst_ready", BUS_W'(o_ready), BUS_W'(0));
        i_reset = 1'b1;
        wait_ready(cycles, saw);
        check("midrst_cycles", BUS_W'(cycles), BUS_W'(32));
        check("midrst_bus_zero", o_bus_debug, '0);

        // post-flush sanity: normal operation resumes
        access(1'b1, SIZE_BYTE, 1'b0, 7'h7E, 32'h000000C3);
        access(1'b0, SIZE_HALF, 1'b0, 7'h7E, 32'h0);
        check("post_ld_half_u", BUS_W'(o_data), BUS_W'(32'h000000C3));
        check("post_valid", BUS_W'(o_valid), BUS_W'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
